// File: rtl/fp_sub_normalizer.sv
// rtl/fp_sub_normalizer.sv - iterative IEEE-754 single post-add/sub normaliser
// Define FP_NORM_ROUND_EN for round-to-nearest-even in the right-shift step.
module fp_sub_normalizer #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_sig,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_underflow,
  output logic        out_overflow
);

  generate
    if (SHIFT_STEP != 1 && SHIFT_STEP != 2 && SHIFT_STEP != 4) begin : g_bad_step
      $error("fp_sub_normalizer: SHIFT_STEP must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RIGHT = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [24:0] sig_q, sig_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        uf_q, uf_d;
  logic        of_q, of_d;

  logic [2:0]  step_n;
  logic        step_stop;
  logic [24:0] sig_ls;
  logic [7:0]  exp_dec;
  logic [24:0] sig_rs;
  logic [7:0]  exp_inc;

  // Per-cycle left shift: stop at the first set bit, the step limit, or exp reaching 1.
  always_comb begin
    step_n    = 3'd0;
    step_stop = 1'b0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (!step_stop && !sig_q[23 - i] && (int'(exp_q) > i + 1)) begin
        step_n = 3'(i + 1);
      end else begin
        step_stop = 1'b1;
      end
    end
  end

  assign sig_ls  = sig_q << step_n;
  assign exp_dec = exp_q - {5'd0, step_n};

  always_comb begin
    sig_rs = {1'b0, sig_q[24:1]};
`ifdef FP_NORM_ROUND_EN
    if (sig_q[0] && sig_rs[0]) begin
      sig_rs = sig_rs + 25'd1;
    end
`endif
  end

  assign exp_inc = exp_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_d    = sig_q;
    result_d = result_q;
    zero_d   = zero_q;
    uf_d     = uf_q;
    of_d     = of_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          sign_d = in_sign;
          exp_d  = in_exp;
          sig_d  = in_sig;
          zero_d = 1'b0;
          uf_d   = 1'b0;
          of_d   = 1'b0;
          if (in_exp == 8'hFF) begin
            state_d  = ST_DONE;
            result_d = {in_sign, 8'hFF, in_sig[22:0]};
            of_d     = 1'b1;
          end else if (in_sig == 25'd0) begin
            state_d  = ST_DONE;
            result_d = {in_sign, 31'd0};
            zero_d   = 1'b1;
          end else if (in_sig[24]) begin
            state_d = ST_RIGHT;
          end else if (in_sig[23]) begin
            state_d  = ST_DONE;
            result_d = {in_sign, (in_exp == 8'd0) ? 8'd1 : in_exp, in_sig[22:0]};
          end else if (in_exp <= 8'd1) begin
            state_d  = ST_DONE;
            result_d = {in_sign, 8'd0, in_sig[22:0]};
            uf_d     = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_RIGHT: begin
        sig_d = sig_rs;
        exp_d = exp_inc;
        if (exp_inc == 8'hFF) begin
          state_d  = ST_DONE;
          result_d = {sign_q, 8'hFF, 23'd0};
          of_d     = 1'b1;
        end else if (sig_rs[24]) begin
          // rounding carried into bit 24: one more right step
          state_d = ST_RIGHT;
        end else begin
          state_d  = ST_DONE;
          result_d = {sign_q, exp_inc, sig_rs[22:0]};
        end
      end
      ST_SHIFT: begin
        sig_d = sig_ls;
        exp_d = exp_dec;
        if (sig_ls[23]) begin
          state_d  = ST_DONE;
          result_d = {sign_q, exp_dec, sig_ls[22:0]};
        end else if (exp_dec == 8'd1) begin
          state_d  = ST_DONE;
          result_d = {sign_q, 8'd0, sig_ls[22:0]};
          uf_d     = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= 8'd0;
      sig_q    <= 25'd0;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sig_q    <= sig_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE) && !reset;
  assign out_valid     = (state_q == ST_DONE);
  assign out_result    = result_q;
  assign out_zero      = zero_q;
  assign out_underflow = uf_q;
  assign out_overflow  = of_q;

endmodule

// File: tb/tb_fp_sub_normalizer.sv
// tb/tb_fp_sub_normalizer.sv - self-checking bench for fp_sub_normalizer
// Reference model works on plain integer significands; FP_NORM_ROUND_EN selects rounding.
module tb_fp_sub_normalizer;

  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_sig;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_underflow;
  logic        out_overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  fp_sub_normalizer #(.SHIFT_STEP(STEP)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_sig        (in_sig),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_underflow (out_underflow),
    .out_overflow  (out_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // flags are packed {overflow, underflow, zero}
  function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                output logic [31:0] res, output logic [2:0] flg, output int lat);
    logic [31:0] mant;
    int ex;
    int k;
    flg = 3'b000;
    lat = 1;
    res = 32'd0;
    if (e == 8'hFF) begin
      res = {s, 8'hFF, m[22:0]};
      flg = 3'b100;
    end else if (m == 25'd0) begin
      res = {s, 31'd0};
      flg = 3'b001;
    end else if (m[24]) begin
      mant = 32'(m) / 2;
      ex   = int'(e) + 1;
      lat  = 2;
`ifdef FP_NORM_ROUND_EN
      if (m[0] && mant[0]) mant = mant + 1;
`endif
      if (ex < 255 && mant >= 32'h1000000) begin
        mant = mant / 2;
        ex   = ex + 1;
        lat  = 3;
      end
      if (ex == 255) begin
        res = {s, 8'hFF, 23'd0};
        flg = 3'b100;
      end else begin
        res = {s, 8'(ex), mant[22:0]};
      end
    end else if (m[23]) begin
      res = {s, (e == 8'd0) ? 8'd1 : e, m[22:0]};
    end else if (e <= 8'd1) begin
      res = {s, 8'd0, m[22:0]};
      flg = 3'b010;
    end else begin
      mant = 32'(m);
      k = 0;
      while (mant < 32'h800000 && k < int'(e) - 1) begin
        mant = mant * 2;
        k++;
      end
      ex  = int'(e) - k;
      lat = 1 + (k + STEP - 1) / STEP;
      if (mant >= 32'h800000) begin
        res = {s, 8'(ex), mant[22:0]};
      end else begin
        res = {s, 8'd0, mant[22:0]};
        flg = 3'b010;
      end
    end
  endfunction

  task automatic rand_op(output logic s, output logic [7:0] e, output logic [24:0] m);
    int kind;
    kind = int'($urandom_range(0, 7));
    s = 1'($urandom);
    e = 8'($urandom);
    m = 25'($urandom);
    case (kind)
      0: e = 8'hFF;
      1: m = 25'd0;
      2: m[24] = 1'b1;
      3: m[24:23] = 2'b01;
      4: begin
        e = 8'($urandom_range(0, 1));
        m[24:23] = 2'b00;
        if (m == 25'd0) m = 25'd1;
      end
      5: begin
        e = 8'hFE;
        m[24] = 1'b1;
      end
      6: begin
        m = 25'(24'($urandom) >> $urandom_range(1, 23));
        if (m == 25'd0) m = 25'd1;
      end
      default: m = 25'h1FFFFFF;
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at the first negedge with out_valid.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                        output logic rdy, output int lat, output logic [31:0] res,
                        output logic [2:0] flg);
    in_sign   = s;
    in_exp    = e;
    in_sig    = m;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    rdy = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    flg = {out_overflow, out_underflow, out_zero};
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_sig    = 25'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 ||
        {out_overflow, out_underflow, out_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b result=%h flags=%b want 0 0 000",
               out_valid, out_result, {out_overflow, out_underflow, out_zero});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t dv[$];
    logic [31:0] r3;
    logic [31:0] mres;
    logic [2:0]  mflg;
    int          mlat;
    logic        rdy;
    int          lat;
    logic [31:0] res;
    logic [2:0]  flg;
`ifdef FP_NORM_ROUND_EN
    r3 = 32'h40800000;
`else
    r3 = 32'h407FFFFF;
`endif
    dv.push_back('{1'b0, 8'h80, 25'h0800000, 32'h40000000, 3'b000});
    dv.push_back('{1'b0, 8'h7F, 25'h1000000, 32'h40000000, 3'b000});
    dv.push_back('{1'b0, 8'h7F, 25'h1FFFFFF, r3,           3'b000});
    dv.push_back('{1'b0, 8'h85, 25'h0010000, 32'h3F000000, 3'b000});
    dv.push_back('{1'b1, 8'h40, 25'h0000000, 32'h80000000, 3'b001});
    dv.push_back('{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b100});
    dv.push_back('{1'b0, 8'h03, 25'h0000100, 32'h00000400, 3'b010});
    dv.push_back('{1'b0, 8'hFF, 25'h0000005, 32'h7F800005, 3'b100});
    dv.push_back('{1'b1, 8'h00, 25'h0800001, 32'h80800001, 3'b000});
    dv.push_back('{1'b0, 8'h01, 25'h0400000, 32'h00400000, 3'b010});
    dv.push_back('{1'b0, 8'h02, 25'h0000001, 32'h00000002, 3'b010});
    foreach (dv[i]) begin
      model(dv[i].s, dv[i].e, dv[i].m, mres, mflg, mlat);
      run_op(dv[i].s, dv[i].e, dv[i].m, rdy, lat, res, flg);
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("FAIL directed_ready[%0d]: got %b want 1", i, rdy);
      end
      checks++;
      if (res !== dv[i].r) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, res, dv[i].r);
      end
      checks++;
      if (flg !== dv[i].f) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got %b want %b", i, flg, dv[i].f);
      end
      checks++;
      if (lat != mlat) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, mlat);
      end
      release_op();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_valid_drop[%0d]: got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_hold();
    logic        rdy;
    int          lat;
    logic [31:0] res;
    logic [2:0]  flg;
    run_op(1'b0, 8'h85, 25'h0010000, rdy, lat, res, flg);
    in_sign  = 1'b1;
    in_exp   = 8'h80;
    in_sig   = 25'h0800000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h3F000000 ||
          {out_overflow, out_underflow, out_zero} !== 3'b000) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b result=%h flags=%b want 1 3f000000 000",
                 c, out_valid, out_result, {out_overflow, out_underflow, out_zero});
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_in_ready[%0d]: got %b want 0", c, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic        vs[N];
    logic [7:0]  ve[N];
    logic [24:0] vm[N];
    logic [31:0] exp_r[$];
    logic [2:0]  exp_f[$];
    int          acc_cyc[$];
    logic [31:0] mres;
    logic [2:0]  mflg;
    int          mlat;
    logic [31:0] want_r;
    logic [2:0]  want_f;
    int          idx;
    int          got;
    int          cyc;
    logic        acc;
    for (int i = 0; i < N; i++) begin
      vs[i] = 1'($urandom);
      ve[i] = 8'($urandom_range(1, 254));
      vm[i] = {2'b01, 23'($urandom)};
    end
    idx = 0;
    got = 0;
    cyc = 0;
    in_sign   = vs[0];
    in_exp    = ve[0];
    in_sig    = vm[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (got < N && cyc < 200) begin
      acc = in_ready && in_valid;
      @(negedge clk);
      cyc++;
      if (acc) begin
        model(vs[idx], ve[idx], vm[idx], mres, mflg, mlat);
        exp_r.push_back(mres);
        exp_f.push_back(mflg);
        acc_cyc.push_back(cyc);
        idx++;
        if (idx < N) begin
          in_sign = vs[idx];
          in_exp  = ve[idx];
          in_sig  = vm[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_output: result=%h with no operand pending", out_result);
        end else begin
          want_r = exp_r.pop_front();
          want_f = exp_f.pop_front();
          if (out_result !== want_r || {out_overflow, out_underflow, out_zero} !== want_f) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", got, out_result,
                     {out_overflow, out_underflow, out_zero}, want_r, want_f);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (got != N) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want %0d", got, N);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i - 1] != 2) begin
        errors++;
        $display("FAIL b2b_interval[%0d]: got %0d want 2", i, acc_cyc[i] - acc_cyc[i - 1]);
      end
    end
  endtask

  task automatic test_random();
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic [31:0] mres;
    logic [2:0]  mflg;
    int          mlat;
    logic        rdy;
    int          lat;
    logic [31:0] res;
    logic [2:0]  flg;
    int          stall;
    for (int n = 0; n < 150; n++) begin
      rand_op(s, e, m);
      model(s, e, m, mres, mflg, mlat);
      run_op(s, e, m, rdy, lat, res, flg);
      checks++;
      if (rdy !== 1'b1 || res !== mres || flg !== mflg || lat != mlat) begin
        errors++;
        $display("FAIL random[%0d] s=%b e=%h m=%h: got rdy=%b %h/%b lat %0d want 1 %h/%b lat %0d",
                 n, s, e, m, rdy, res, flg, lat, mres, mflg, mlat);
      end
      stall = int'($urandom_range(0, 2));
      repeat (stall) @(negedge clk);
      checks++;
      if (out_result !== mres) begin
        errors++;
        $display("FAIL random_stall_hold[%0d]: got %h want %h", n, out_result, mres);
      end
      release_op();
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    in_sign   = 1'b0;
    in_exp    = 8'h90;
    in_sig    = 25'h0000001;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_shift: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    checks++;
    if (out_result !== 32'd0 || {out_overflow, out_underflow, out_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_shift_clear: result=%h flags=%b want 0 000",
               out_result, {out_overflow, out_underflow, out_zero});
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_shift_discard: out_valid seen %0d cycles want 0", seen);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_sub_normalizer.md
# fp_sub_normalizer

Iterative post-add/subtract normalisation stage for IEEE-754 single precision. It consumes the raw sign, exponent and 25-bit significand sum/difference produced by the add/subtract datapath. It renormalises over one or more clock cycles and delivers a packed 32-bit result with status flags. Valid/ready handshakes on both sides let it sit between the arithmetic stage and the ALU result register.

## Interface
- `SHIFT_STEP`, default 1: maximum left-shift distance per cycle. Legal values are 1, 2, 4; any other value is a synthesis error.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: synchronous, active-high reset. One clock; reset is sampled only on `clk` rising edge.
- `in_valid` input, 1 bit: upstream presents an operand.
- `in_ready` output, 1 bit: equals (state==IDLE) && !reset.
- `in_sign` input, 1 bit: result sign.
- `in_exp` input, 8 bits: unnormalised biased exponent.
- `in_sig` input, 25 bits: bit24 is the carry, bit23 is the hidden bit, bits 22:0 are the fraction.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: downstream accepts the result.
- `out_result` output, 32 bits: packed IEEE-754 result.
- `out_zero` output, 1 bit: the result is ±0.
- `out_underflow` output, 1 bit: the result is subnormal (exponent field 0, fraction ≠ 0).
- `out_overflow` output, 1 bit: the result is ±infinity or the input exponent was 255.

## Operation
- States: IDLE, RIGHT, SHIFT, DONE. On reset the block enters IDLE and clears `out_valid`, `out_result` and all flags to 0.
- IDLE: on `in_valid && in_ready`, latch sign, exp and sig, then classify in this priority order:
  - `in_exp`==255 → DONE. Result {sign, 8'hFF, sig[22:0]}, `out_overflow`=1.
  - sig==0 → DONE. Result {sign, 31'b0}, `out_zero`=1.
  - sig[24]=1 → RIGHT.
  - sig[23]=1 → DONE. If exp==0, the exponent becomes 1.
  - exp==0 or exp==1 with sig[23]=0 → DONE as subnormal.
  - Otherwise → SHIFT.
- RIGHT (one cycle): sig ← sig>>1 with bit0 dropped; exp ← exp+1.
  - If the new exp==255 → DONE with result {sign, 8'hFF, 23'b0} and `out_overflow`=1.
  - Otherwise → DONE.
- SHIFT: each cycle shift left by n = min(SHIFT_STEP, leading zeros of sig[23:0], exp−1), and set exp ← exp−n.
  - Leave SHIFT when sig[23]=1 or exp==1.
  - If exp==1 and sig[23]=0 on exit, the result is subnormal: exponent field 0, fraction sig[22:0], `out_underflow`=1.
- DONE: `out_valid`=1.
  - `out_result` and the flags are held stable while `out_ready`=0.
  - On `out_valid && out_ready`, the next state is IDLE and `out_valid` drops the next cycle.
  - Normal result: {sign, exp, sig[22:0]}. Flags are mutually exclusive.
- Reset has priority over every state. Reset mid-SHIFT or in DONE discards the operand with no output.
- An input presented while busy is not accepted; `in_valid` may stay high.

## Timing
- Accept at edge t. With no shift required, `out_valid` is high from t+1.
- RIGHT path: `out_valid` from t+2 (t+3 when the rounding carry described under Configuration occurs).
- SHIFT path with k total shift bits: `out_valid` from t+1+ceil(k/SHIFT_STEP). Maximum 23 shift cycles at STEP=1.
- Minimum initiation interval is 2 cycles: the accept cycle plus one DONE cycle with `out_ready`=1. There is no same-cycle re-accept.
- `in_ready` is combinational from the state register only; there is no combinational path from `out_ready` to `in_ready`.

## Configuration
- `FP_NORM_ROUND_EN` defined: RIGHT performs round-to-nearest-even on the dropped bit.
  - If the dropped bit is 1 and sig[0] after the shift is 1, increment sig.
  - If the increment sets bit24 again, perform one more RIGHT cycle (exp+1, overflow check repeated).
- `FP_NORM_ROUND_EN` undefined: RIGHT truncates, and RIGHT always lasts exactly one cycle.

## Test plan
- exp=8'h80, sig=25'h0800000, sign=0 → `out_valid` at t+1, `out_result`=32'h40000000, all flags 0.
- exp=8'h7F, sig=25'h1000000 → `out_result`=32'h40000000 at t+2. With `FP_NORM_ROUND_EN` and sig=25'h1FFFFFF → 32'h40800000 at t+3.
- exp=8'h85, sig=25'h0010000 → `out_result`=32'h3F000000 at t+8 (STEP=1) and at t+3 (STEP=4).
- sign=1, sig=0 → `out_result`=32'h80000000 and `out_zero`=1 at t+1. exp=8'hFE, sig=25'h1000000 → 32'h7F800000 and `out_overflow`=1.
- exp=8'h03, sig=25'h0000100 → `out_result`=32'h00000400 and `out_underflow`=1 at t+3.
- Hold `out_ready`=0 for 5 cycles in DONE → result stable and `in_ready`=0. Assert reset during SHIFT → `out_valid`=0 and `in_ready`=1 on the cycle after reset deasserts.
